// File: rtl/regfile_access_unit.sv
// regfile_access_unit: decode-to-execute operand fetch with a per-register busy scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writebacks into hazard check and operands.
module regfile_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_wr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_dst,
  output logic              op_wr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_addr_r1,
  output logic [ADDR_W-1:0] rf_addr_r2,
  input  logic [DATA_W-1:0] rf_data_out1,
  input  logic [DATA_W-1:0] rf_data_out2,
  output logic [NREGS-1:0]  busy_mask,
  output logic              wb_err
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NREGS-1:0]    r_busy;
  logic [NREGS-1:0]    w_busy_next;
  logic [NREGS-1:0]    w_busy_eff;
  logic [NREGS-1:0]    w_wb_onehot;
  logic [NREGS-1:0]    w_set_onehot;
  logic                r_wb_err;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [ADDR_W-1:0]   r_op_dst;
  logic                r_op_wr;
  logic [DATA_W-1:0]   w_opnd_a;
  logic [DATA_W-1:0]   w_opnd_b;
  logic                w_hazard;
  logic                w_ready;
  logic                w_accept;

  // Per-register scoreboard update; a new reservation beats a same-cycle writeback clear.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
      assign w_wb_onehot[gi]  = wb_valid && (wb_addr == ADDR_W'(gi));
      assign w_set_onehot[gi] = w_accept && issue_wr && (issue_dst == ADDR_W'(gi));
      assign w_busy_next[gi]  = w_set_onehot[gi] | (r_busy[gi] & ~w_wb_onehot[gi]);
    end
  endgenerate

`ifdef REGFILE_WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wb_onehot;
  assign w_opnd_a   = (wb_valid && (wb_addr == issue_src1)) ? wb_data : rf_data_out1;
  assign w_opnd_b   = (wb_valid && (wb_addr == issue_src2)) ? wb_data : rf_data_out2;
`else
  assign w_busy_eff = r_busy;
  assign w_opnd_a   = rf_data_out1;
  assign w_opnd_b   = rf_data_out2;
`endif

  assign w_hazard = w_busy_eff[issue_src1] | w_busy_eff[issue_src2] |
                    (issue_wr & w_busy_eff[issue_dst]);
  assign w_ready  = !rst && !w_hazard && ((r_state == S_EMPTY) || op_ready);
  assign w_accept = issue_valid && w_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_next = S_FULL;
      S_FULL:  if (op_ready && !w_accept) w_state_next = S_EMPTY;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_busy   <= '0;
      r_wb_err <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_dst <= '0;
      r_op_wr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
      if (wb_valid && !r_busy[wb_addr]) r_wb_err <= 1'b1;
      if (w_accept) begin
        r_op_a   <= w_opnd_a;
        r_op_b   <= w_opnd_b;
        r_op_dst <= issue_dst;
        r_op_wr  <= issue_wr;
      end
    end
  end

  assign issue_ready     = w_ready;
  assign op_valid        = (r_state == S_FULL);
  assign op_a            = r_op_a;
  assign op_b            = r_op_b;
  assign op_dst          = r_op_dst;
  assign op_wr           = r_op_wr;
  assign rf_write_enable = wb_valid && !rst;
  assign rf_addr_w       = wb_addr;
  assign rf_data_in      = wb_data;
  assign rf_addr_r1      = issue_src1;
  assign rf_addr_r2      = issue_src2;
  assign busy_mask       = r_busy;
  assign wb_err          = r_wb_err;

endmodule

// File: tb/tb_regfile_access_unit.sv
// Bench for regfile_access_unit: attached 16x16 regfile, abstract reference model, per-cycle compare.
module tb_regfile_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, issue_ready, issue_wr = 1'b0;
  logic [3:0]  issue_src1 = '0, issue_src2 = '0, issue_dst = '0;
  logic        op_valid, op_ready = 1'b0, op_wr;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_dst;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        rf_write_enable;
  logic [3:0]  rf_addr_w, rf_addr_r1, rf_addr_r2;
  logic [15:0] rf_data_in, rf_data_out1, rf_data_out2;
  logic [15:0] busy_mask;
  logic        wb_err;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic tb_clr = 1'b1;

  always #5 clk = ~clk;

  regfile_access_unit dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_dst(issue_dst), .issue_wr(issue_wr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_dst(op_dst), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_write_enable(rf_write_enable), .rf_addr_w(rf_addr_w), .rf_data_in(rf_data_in),
    .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  // Register file attached to the unit: combinational read, posedge write.
  logic [15:0] rf_mem [16];
  assign rf_data_out1 = rf_mem[rf_addr_r1];
  assign rf_data_out2 = rf_mem[rf_addr_r2];
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (rf_write_enable) begin
      rf_mem[rf_addr_w] <= rf_data_in;
    end
  end

  // Reference model: architectural register values, set of pending writers, one operand slot.
  logic [15:0] m_rf [16];
  logic [15:0] m_busy = '0;
  logic        m_err = 1'b0, m_full = 1'b0, m_wr = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [3:0]  m_dst = '0;

  function automatic logic m_ready_f();
    logic [15:0] pend;
    logic        conflict;
    pend = m_busy;
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_valid) pend[wb_addr] = 1'b0;
`endif
    conflict = pend[issue_src1] || pend[issue_src2] || (issue_wr && pend[issue_dst]);
    return !rst && !conflict && (!m_full || op_ready);
  endfunction

  function automatic logic [15:0] m_val(input logic [3:0] r);
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_valid && wb_addr == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) m_rf[i] <= '0;
    end
    if (rst) begin
      m_busy <= '0; m_err <= 1'b0; m_full <= 1'b0;
      m_a <= '0; m_b <= '0; m_dst <= '0; m_wr <= 1'b0;
    end else begin
      if (wb_valid) begin
        m_rf[wb_addr] <= wb_data;
        if (m_busy[wb_addr]) m_busy[wb_addr] <= 1'b0;
        else m_err <= 1'b1;
      end
      if (issue_valid && m_ready_f()) begin
        m_full <= 1'b1;
        m_a <= m_val(issue_src1); m_b <= m_val(issue_src2);
        m_dst <= issue_dst; m_wr <= issue_wr;
        if (issue_wr) m_busy[issue_dst] <= 1'b1;
      end else if (op_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_valid", op_valid, m_full);
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
      chk("op_dst", op_dst, m_dst);
      chk("op_wr", op_wr, m_wr);
      chk("busy_mask", busy_mask, m_busy);
      chk("wb_err", wb_err, m_err);
      chk("issue_ready", issue_ready, m_ready_f());
      chk("rf_we", rf_write_enable, wb_valid && !rst);
      chk("rf_addr_r1", rf_addr_r1, issue_src1);
      chk("rf_addr_r2", rf_addr_r2, issue_src2);
      if (wb_valid) begin
        chk("rf_addr_w", rf_addr_w, wb_addr);
        chk("rf_data_in", rf_data_in, wb_data);
      end
    end
  end

  task automatic do_wb(input logic [3:0] a, input logic [15:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic do_issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                          input logic w);
    int n;
    issue_valid = 1'b1; issue_src1 = s1; issue_src2 = s2; issue_dst = d; issue_wr = w;
    n = 0;
    @(negedge clk);
    while (!issue_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept_wait", issue_ready, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  initial begin
    int n_acc, n_con, cyc;
    logic acc, con;

    // 1: reset
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_op_a", op_a, 16'h0);
    chk("rst_busy", busy_mask, 16'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    chk("rst_ready_low", issue_ready, 1'b0);
    @(posedge clk); #1; rst = 1'b0; tb_clr = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", issue_ready, 1'b1);
    @(posedge clk); #1;

    // 2: load and issue
    do_wb(4'd3, 16'h1234);
    do_wb(4'd5, 16'h00FF);
    op_ready = 1'b0;
    do_issue(4'd3, 4'd5, 4'd7, 1'b1);
    @(negedge clk);
    chk("t2_op_valid", op_valid, 1'b1);
    chk("t2_op_a", op_a, 16'h1234);
    chk("t2_op_b", op_b, 16'h00FF);
    chk("t2_op_dst", op_dst, 4'd7);
    chk("t2_busy", busy_mask, 16'h0080);

    // 3: RAW stall on r7 until its writeback
    @(posedge clk); #1;
    op_ready = 1'b1;
    issue_valid = 1'b1; issue_src1 = 4'd7; issue_src2 = 4'd0; issue_dst = 4'd1; issue_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_stall", issue_ready, 1'b0);
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF;
    @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
    chk("t3_ready_wb_cycle", issue_ready, 1'b1);
`else
    chk("t3_ready_wb_cycle", issue_ready, 1'b0);
`endif
    @(posedge clk); #1;
    wb_valid = 1'b0;
`ifndef REGFILE_WB_BYPASS_EN
    @(negedge clk);
    chk("t3_ready_after_wb", issue_ready, 1'b1);
    @(posedge clk); #1;
`endif
    issue_valid = 1'b0;
    op_ready = 1'b0;
    @(negedge clk);
    chk("t3_op_a", op_a, 16'hBEEF);
    chk("t3_op_valid", op_valid, 1'b1);

    // 4: backpressure holds the slot, then release
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_src1 = 4'd3; issue_src2 = 4'd5; issue_dst = 4'd2; issue_wr = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_blocked", issue_ready, 1'b0);
      chk("t4_hold_a", op_a, 16'hBEEF);
      @(posedge clk); #1;
    end
    op_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready", issue_ready, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t4_second_a", op_a, 16'h1234);
    chk("t4_second_valid", op_valid, 1'b1);

    // 4b: 20 random back-to-back issues under random backpressure
    @(posedge clk); #1;
    n_acc = 0; n_con = 0; cyc = 0;
    issue_valid = 1'b1; issue_wr = 1'b0;
    issue_src1 = 4'($urandom_range(0, 15)); issue_src2 = 4'($urandom_range(0, 15));
    issue_dst = 4'($urandom_range(0, 15));
    op_ready = 1'($urandom_range(0, 1));
    while (n_acc < 20 && cyc < 400) begin
      @(negedge clk);
      acc = issue_valid && issue_ready;
      con = op_valid && op_ready;
      @(posedge clk); #1;
      cyc++;
      if (con) n_con++;
      if (acc) begin
        n_acc++;
        issue_src1 = 4'($urandom_range(0, 15)); issue_src2 = 4'($urandom_range(0, 15));
        issue_dst = 4'($urandom_range(0, 15));
        if (n_acc == 20) issue_valid = 1'b0;
      end
      op_ready = 1'($urandom_range(0, 1));
    end
    op_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (op_valid && op_ready) n_con++;
      @(posedge clk); #1;
    end
    chk("rand_accepts", 32'(n_acc), 32'd20);
    chk("rand_consumed", 32'(n_con), 32'd20);

    // clear the sticky error picked up by the initial loads
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("clr_wb_err", wb_err, 1'b0);
    @(posedge clk); #1;

    // 5: writeback to a non-busy register
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 16'h0001;
    @(negedge clk);
    chk("t5_rf_we", rf_write_enable, 1'b1);
    @(posedge clk); #1; wb_valid = 1'b0;
    @(negedge clk);
    chk("t5_wb_err", wb_err, 1'b1);
    chk("t5_busy", busy_mask, 16'h0);
    op_ready = 1'b1;
    do_issue(4'd9, 4'd9, 4'd0, 1'b0);
    @(negedge clk);
    chk("t5_readback", op_a, 16'h0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_err_sticky", wb_err, 1'b1);

    // 6: reset in the middle of activity
    @(posedge clk); #1;
    op_ready = 1'b0;
    do_issue(4'd0, 4'd0, 4'd5, 1'b1);
    op_ready = 1'b1;
    do_issue(4'd0, 4'd0, 4'd7, 1'b1);
    op_ready = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy_mask, 16'h00A0);
    chk("t6_op_valid", op_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h5555;
    @(negedge clk);
    chk("t6_rf_we", rf_write_enable, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("t6_op_valid", op_valid, 1'b0);
    chk("t6_busy_clr", busy_mask, 16'h0);
    chk("t6_wb_err", wb_err, 1'b0);
    chk("t6_op_a", op_a, 16'h0);
    op_ready = 1'b1;
    do_issue(4'd5, 4'd7, 4'd0, 1'b0);
    @(negedge clk);
    chk("t6_r5_kept", op_a, 16'h00FF);
    chk("t6_r7_kept", op_b, 16'hBEEF);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
